// File: rtl/wb_stage.sv
// PIGRO write-back stage: selects ALU/load result, drives the register-file
// write port and forwarding bus, clears all registers after reset.
module wb_stage #(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       pc,
  input  logic [4:0]       opcode,
  input  logic [31:0]      aluout,
  input  logic [31:0]      LMD,
  input  logic [3:0]       dest_addr,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [3:0]       fwd_addr,
  output logic [31:0]      fwd_data,
  output logic [4:0]       retired_pc,
  output logic [CNT_W-1:0] retire_count,
  output logic             illegal_op,
  output logic             init_done
);

  // PIGRO opcode map: NOP, ALU ops 1..ARSH, then load and store
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ARSH = 5'd10;
  localparam logic [4:0] OP_LDW  = 5'd11;
  localparam logic [4:0] OP_STR  = 5'd12;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             rf_we_q;
  logic [3:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;
  logic [4:0]       retired_pc_q;
  logic [CNT_W-1:0] retire_count_q;
  logic             illegal_op_q;

  logic is_nop;
  logic is_alu;
  logic is_ldw;
  logic is_str;

  assign is_nop = (opcode == OP_NOP);
  assign is_alu = (opcode > OP_NOP) && (opcode <= OP_ARSH);
  assign is_ldw = (opcode == OP_LDW);
  assign is_str = (opcode == OP_STR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= CLEAR_ON_RESET ? INIT : RUN;
      cnt_q          <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      retired_pc_q   <= '0;
      retire_count_q <= '0;
      illegal_op_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= cnt_q;
          rf_wdata_q <= '0;
          cnt_q      <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= RUN;
        end
        default: begin
          rf_we_q <= 1'b0;
          if (in_valid) begin
            retired_pc_q   <= pc;
            retire_count_q <= retire_count_q + CNT_W'(1);
            unique case (1'b1)
              is_alu: begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= dest_addr;
                rf_wdata_q <= aluout;
              end
              is_ldw: begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= dest_addr;
                rf_wdata_q <= LMD;
              end
              is_nop: ;
              is_str: ;
              default: illegal_op_q <= 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  assign in_ready     = (state_q == RUN);
  assign init_done    = (state_q == RUN);
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign fwd_valid    = rf_we_q & init_done;
  assign fwd_addr     = rf_waddr_q;
  assign fwd_data     = rf_wdata_q;
  assign retired_pc   = retired_pc_q;
  assign retire_count = retire_count_q;
  assign illegal_op   = illegal_op_q;

endmodule
